// File: rtl/cond_unit.sv
// cond_unit -- execute-stage condition evaluation and E/M control boundary.
//
// Takes the condition field of the instruction in E and checks it against the
// architectural flag register (FlagsQ), never against the flags the ALU is
// producing this cycle. The pass result is used in three ways:
//   - it gates the branch redirect request to fetch (combinational);
//   - it gates the flag-register write;
//   - it gates the register/memory write enables into the M stage.
// A failed-condition instruction still flows into M as a valid instruction.
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   CondE        condition field of the instruction in E
//   FlagsE       ALU flags {N,Z,C,V} for the instruction in E
//   FlagWriteE   bit1 writes N,Z ; bit0 writes C,V
//   ValidE       E holds a real instruction (0 = bubble)
//   PCSrcE, RegWriteE, MemWriteE, MemtoRegE   ungated E-stage controls
//   StallM       hold the flag register and all M registers
//   FlushM       load a bubble into the M registers
//   CondExE      condition pass for E (combinational)
//   PCSrcTakenE  redirect request to fetch (combinational)
//   RegWriteM, MemWriteM, MemtoRegM, ValidM   registered gated controls
//   FlagsQ       architectural flag register {N,Z,C,V}

module cond_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] CondE,
    input  logic [3:0] FlagsE,
    input  logic [1:0] FlagWriteE,
    input  logic       ValidE,
    input  logic       PCSrcE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    input  logic       MemtoRegE,
    input  logic       StallM,
    input  logic       FlushM,
    output logic       CondExE,
    output logic       PCSrcTakenE,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic       MemtoRegM,
    output logic       ValidM,
    output logic [3:0] FlagsQ
);

    logic flag_n, flag_z, flag_c, flag_v;
    logic go;

    assign {flag_n, flag_z, flag_c, flag_v} = FlagsQ;

    always_comb begin
        CondExE = 1'b0;
        case (CondE)
            4'b0000: CondExE = flag_z;
            4'b0001: CondExE = ~flag_z;
            4'b0010: CondExE = flag_c;
            4'b0011: CondExE = ~flag_c;
            4'b0100: CondExE = flag_n;
            4'b0101: CondExE = ~flag_n;
            4'b0110: CondExE = flag_v;
            4'b0111: CondExE = ~flag_v;
            4'b1000: CondExE = flag_c & ~flag_z;
            4'b1001: CondExE = ~flag_c | flag_z;
            4'b1010: CondExE = (flag_n == flag_v);
            4'b1011: CondExE = (flag_n != flag_v);
            4'b1100: CondExE = ~flag_z & (flag_n == flag_v);
            4'b1101: CondExE = flag_z | (flag_n != flag_v);
            default: CondExE = 1'b1;
        endcase
    end

    assign go          = CondExE & ValidE;
    // A stalled instruction will be re-presented next cycle, so it must not
    // redirect fetch yet.
    assign PCSrcTakenE = PCSrcE & go & ~StallM;

    // Flags are owned by the instruction in E; a flush of M does not cancel
    // them, only a stall (which re-presents E) does.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            FlagsQ <= 4'b0000;
        end else if (!StallM && go) begin
            if (FlagWriteE[1]) FlagsQ[3:2] <= FlagsE[3:2];
            if (FlagWriteE[0]) FlagsQ[1:0] <= FlagsE[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            ValidM    <= 1'b0;
        end else if (FlushM) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            ValidM    <= 1'b0;
        end else if (!StallM) begin
            RegWriteM <= RegWriteE & go;
            MemWriteM <= MemWriteE & go;
            // Result-select only steers the writeback mux; gating by validity
            // is enough since the write enable carries the condition.
            MemtoRegM <= MemtoRegE & ValidE;
            ValidM    <= ValidE;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

    logic       clk;
    logic       reset_n;
    logic [3:0] CondE;
    logic [3:0] FlagsE;
    logic [1:0] FlagWriteE;
    logic       ValidE, PCSrcE, RegWriteE, MemWriteE, MemtoRegE, StallM, FlushM;
    logic       CondExE, PCSrcTakenE, RegWriteM, MemWriteM, MemtoRegM, ValidM;
    logic [3:0] FlagsQ;

    int tests = 0;
    int fails = 0;

    cond_unit dut (
        .clk(clk), .reset_n(reset_n), .CondE(CondE), .FlagsE(FlagsE),
        .FlagWriteE(FlagWriteE), .ValidE(ValidE), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .StallM(StallM), .FlushM(FlushM), .CondExE(CondExE),
        .PCSrcTakenE(PCSrcTakenE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM), .ValidM(ValidM), .FlagsQ(FlagsQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {cond, flagsE, fw, {v,pc,rw,mw,m2r,st,fl}, {cx,pt,rwm,mwm,m2rm,vm}, fq}
    typedef struct packed {
        logic [3:0] cond;
        logic [3:0] flg;
        logic [1:0] fw;
        logic [6:0] ctl;
        logic [5:0] exp;
        logic [3:0] efq;
    } vec_t;

    vec_t tbl [14];

    // Reference model state
    logic [3:0] m_flags;
    logic       m_rw, m_mw, m_m2r, m_vm;

    // Condition model: pairs of conditions, odd code is the negation of the
    // even one; the 111x pair is always true.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, vv, base;
        {n, z, cc, vv} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = vv;
            3'd4: base = cc && !z;
            3'd5: base = (n == vv);
            3'd6: base = !z && (n == vv);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        m_rw = 1'b0; m_mw = 1'b0; m_m2r = 1'b0; m_vm = 1'b0;
    endtask

    // Apply one E-stage cycle. use_tbl selects the table's expected values,
    // otherwise the reference model's. The model is always advanced.
    task automatic step(input vec_t v, input bit use_tbl);
        logic go, cx, pt;
        logic [5:0] e;
        logic [3:0] fq;
        {ValidE, PCSrcE, RegWriteE, MemWriteE, MemtoRegE, StallM, FlushM} = v.ctl;
        CondE = v.cond; FlagsE = v.flg; FlagWriteE = v.fw;
        #1;
        cx = cond_pass(v.cond, m_flags);
        go = cx & v.ctl[6];
        pt = v.ctl[5] & go & ~v.ctl[1];
        if (!v.ctl[1] && go) begin
            if (v.fw[1]) m_flags[3:2] = v.flg[3:2];
            if (v.fw[0]) m_flags[1:0] = v.flg[1:0];
        end
        if (v.ctl[0]) begin
            m_rw = 1'b0; m_mw = 1'b0; m_m2r = 1'b0; m_vm = 1'b0;
        end else if (!v.ctl[1]) begin
            m_rw = v.ctl[4] & go; m_mw = v.ctl[3] & go;
            m_m2r = v.ctl[2] & v.ctl[6]; m_vm = v.ctl[6];
        end
        if (use_tbl) begin
            e = v.exp; fq = v.efq;
        end else begin
            e = {cx, pt, m_rw, m_mw, m_m2r, m_vm}; fq = m_flags;
        end
        check("CondExE", {3'b0, CondExE}, {3'b0, e[5]});
        check("PCSrcTakenE", {3'b0, PCSrcTakenE}, {3'b0, e[4]});
        @(posedge clk);
        #1;
        check("M_controls", {RegWriteM, MemWriteM, MemtoRegM, ValidM}, e[3:0]);
        check("FlagsQ", FlagsQ, fq);
    endtask

    initial begin
        vec_t rv;

        tbl[0]  = {4'b0000, 4'b1111, 2'b00, 7'b1000000, 6'b000001, 4'b0000};
        tbl[1]  = {4'b1110, 4'b1111, 2'b10, 7'b1110000, 6'b111001, 4'b1100};
        tbl[2]  = {4'b1110, 4'b1111, 2'b01, 7'b1001100, 6'b100111, 4'b1111};
        tbl[3]  = {4'b1110, 4'b0100, 2'b11, 7'b1000000, 6'b100001, 4'b0100};
        tbl[4]  = {4'b0001, 4'b1011, 2'b11, 7'b1111100, 6'b000011, 4'b0100};
        tbl[5]  = {4'b1110, 4'b1011, 2'b11, 7'b1111010, 6'b100011, 4'b0100};
        tbl[6]  = {4'b1110, 4'b1011, 2'b11, 7'b1111011, 6'b100000, 4'b0100};
        tbl[7]  = {4'b1110, 4'b1011, 2'b11, 7'b1111001, 6'b110000, 4'b1011};
        tbl[8]  = {4'b1110, 4'b0000, 2'b11, 7'b0111100, 6'b100000, 4'b1011};
        tbl[9]  = {4'b1110, 4'b0100, 2'b11, 7'b1000000, 6'b100001, 4'b0100};
        tbl[10] = {4'b0000, 4'b0000, 2'b00, 7'b1110000, 6'b111001, 4'b0100};
        tbl[11] = {4'b1110, 4'b1001, 2'b11, 7'b1000000, 6'b100001, 4'b1001};
        tbl[12] = {4'b1010, 4'b0000, 2'b00, 7'b1010000, 6'b101001, 4'b1001};
        tbl[13] = {4'b1011, 4'b0000, 2'b00, 7'b1010000, 6'b000001, 4'b1001};

        // Reset with no clock edge yet; junk on the inputs.
        reset_n = 1'b0;
        CondE = 4'b1110; FlagsE = 4'b1111; FlagWriteE = 2'b11;
        {ValidE, PCSrcE, RegWriteE, MemWriteE, MemtoRegE, StallM, FlushM} = 7'b1111100;
        model_reset();
        #2;
        check("reset_flags", FlagsQ, 4'b0000);
        check("reset_M", {RegWriteM, MemWriteM, MemtoRegM, ValidM}, 4'b0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        CondE = 4'b0000;
        #1;
        check("reset_eq_fails", {3'b0, CondExE}, 4'b0000);

        // Directed table
        for (int i = 0; i < 14; i++) step(tbl[i], 1'b1);

        // Full condition sweep against every flag value
        for (int f = 0; f < 16; f++) begin
            rv = '0;
            rv.cond = 4'b1110; rv.flg = 4'(f); rv.fw = 2'b11; rv.ctl = 7'b1000000;
            step(rv, 1'b0);
            for (int c = 0; c < 16; c++) begin
                CondE = 4'(c);
                #1;
                check($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, CondExE},
                      {3'b0, cond_pass(4'(c), 4'(f))});
            end
        end

        // Randomized cycles against the model
        for (int i = 0; i < 400; i++) begin
            rv = '0;
            rv.cond = 4'($urandom_range(0, 15));
            rv.flg  = 4'($urandom_range(0, 15));
            rv.fw   = 2'($urandom_range(0, 3));
            rv.ctl[6:2] = 5'($urandom_range(0, 31));
            rv.ctl[1] = ($urandom_range(0, 3) == 0);
            rv.ctl[0] = ($urandom_range(0, 4) == 0);
            step(rv, 1'b0);
        end

        // Reset asserted mid-stall and mid-flush, between edges
        rv = '0;
        rv.cond = 4'b1110; rv.flg = 4'b1111; rv.fw = 2'b11; rv.ctl = 7'b1111100;
        step(rv, 1'b0);
        StallM = 1'b1; FlushM = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrun_reset_flags", FlagsQ, 4'b0000);
        check("midrun_reset_M", {RegWriteM, MemWriteM, MemtoRegM, ValidM}, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", {FlagsQ[3:0]}, 4'b0000);
        reset_n = 1'b1;
        StallM = 1'b0; FlushM = 1'b0;
        rv = '0;
        rv.cond = 4'b1110; rv.flg = 4'b0110; rv.fw = 2'b11; rv.ctl = 7'b1100000;
        step(rv, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
